// File: rtl/usb_packet_framer.sv
// Byte-stream to 64-bit packet framer: hunts for SOF, collects eight payload bytes plus an
// XOR check byte, and hands verified packets to the analyzer through a one-entry buffer.
module usb_packet_framer #(
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic [63:0]          pkt_data,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic                 err_chk,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           xor_q, xor_d;
  logic [63:0]          asm_q, asm_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic [63:0]          pkt_data_d;
  logic                 pkt_valid_d;
  logic                 err_chk_d, err_overrun_d, err_timeout_d;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic                 buf_free;
  logic                 timeout_hit;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    xor_d         = xor_q;
    asm_d         = asm_q;
    idle_d        = idle_q;
    pkt_data_d    = pkt_data;
    pkt_valid_d   = pkt_valid & ~pkt_ready;
    err_chk_d     = 1'b0;
    err_overrun_d = 1'b0;
    err_timeout_d = 1'b0;
    err_count_d   = err_count;

    // The buffer can take a new packet when empty or being drained this very cycle.
    buf_free    = ~pkt_valid | pkt_ready;
    timeout_hit = (state_q != IDLE) && !in_valid && (idle_q == IDLE_MAX);

    unique case (state_q)
      IDLE: begin
        idle_d = '0;
        if (in_valid && in_byte == SOF) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          xor_d   = '0;
        end
      end

      PAYLOAD: begin
        if (in_valid) begin
          // Shifting in from the bottom leaves payload byte 0 in [63:56] after eight bytes.
          asm_d  = {asm_q[55:0], in_byte};
          xor_d  = xor_q ^ in_byte;
          idx_d  = idx_q + 3'd1;
          idle_d = '0;
          if (idx_q == 3'd7) state_d = CHECK;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          idle_d        = '0;
          err_timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      CHECK: begin
        if (in_valid) begin
          state_d = IDLE;
          idle_d  = '0;
          if (in_byte != xor_q) begin
            err_chk_d = 1'b1;
          end else if (buf_free) begin
            pkt_data_d  = asm_q;
            pkt_valid_d = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d       = IDLE;
          idle_d        = '0;
          err_timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idle_d  = '0;
      end
    endcase

    if ((err_chk_d | err_overrun_d | err_timeout_d) && err_count != '1)
      err_count_d = err_count + ERR_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      xor_q       <= '0;
      asm_q       <= '0;
      idle_q      <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      err_chk     <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      asm_q       <= asm_d;
      idle_q      <= idle_d;
      pkt_data    <= pkt_data_d;
      pkt_valid   <= pkt_valid_d;
      err_chk     <= err_chk_d;
      err_overrun <= err_overrun_d;
      err_timeout <= err_timeout_d;
      err_count   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_usb_packet_framer.sv
// Self-checking bench for usb_packet_framer: directed scenarios plus randomized frames
// compared against a frame-level reference model (XOR rule, packet queue, saturating count).
module tb_usb_packet_framer;

  localparam int         TO      = 1024;
  localparam int         ERR_MAX = 255;
  localparam logic [7:0] SOF     = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic        err_chk, err_overrun, err_timeout;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int n_chk = 0;
  int n_ovr = 0;
  int n_to  = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  usb_packet_framer #(
    .SOF(SOF),
    .TIMEOUT_CYCLES(TO),
    .ERR_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .pkt_data(pkt_data),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .err_chk(err_chk),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .err_count(err_count)
  );

  // Monitor on the falling edge: records handshakes and counts error pulse cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid && pkt_ready) got_q.push_back(pkt_data);
      if (err_chk) n_chk++;
      if (err_overrun) n_ovr++;
      if (err_timeout) n_to++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] xsum(input logic [63:0] p);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 8; i++) c ^= p[8*i +: 8];
    return c;
  endfunction

  function automatic int sat_add(input int a, input int k);
    return (a + k > ERR_MAX) ? ERR_MAX : a + k;
  endfunction

  // One clock of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic [7:0] b, input logic r);
    in_valid  = v;
    in_byte   = b;
    pkt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b0, 8'($urandom), r);
  endtask

  task automatic send_frame(input logic [63:0] p, input logic [7:0] chk, input int max_gap,
                            input logic r, input logic r_chk);
    drive(1'b1, SOF, r);
    for (int i = 7; i >= 0; i--) begin
      idle($urandom_range(0, max_gap), r);
      drive(1'b1, p[8*i +: 8], r);
    end
    idle($urandom_range(0, max_gap), r);
    drive(1'b1, chk, r_chk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_pkt_valid got=%0b want=0", pkt_valid); end
    total++; if (pkt_data !== 64'h0) begin bad++; $display("FAIL reset_pkt_data got=%h want=0", pkt_data); end
    total++; if ({err_chk, err_overrun, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL reset_err_pulses got=%b want=000", {err_chk, err_overrun, err_timeout});
    end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
  endtask

  task automatic test_good_frame;
    int c0 = n_chk, o0 = n_ovr, t0 = n_to;
    got_q.delete();
    send_frame(64'h0102030405060708, 8'h08, 0, 1'b1, 1'b1);
    total++; if (pkt_valid !== 1'b1) begin bad++; $display("FAIL good_latency pkt_valid got=%0b want=1", pkt_valid); end
    total++; if (pkt_data !== 64'h0102030405060708) begin
      bad++; $display("FAIL good_data got=%h want=0102030405060708", pkt_data);
    end
    idle(1, 1'b1);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL good_one_cycle pkt_valid got=%0b want=0", pkt_valid); end
    idle(2, 1'b1);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL good_accepts got=%0d want=1", got_q.size()); end
    total++; if (n_chk + n_ovr + n_to != c0 + o0 + t0) begin
      bad++; $display("FAIL good_no_errors got=%0d want=0", n_chk + n_ovr + n_to - c0 - o0 - t0);
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL good_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_bad_check;
    int c0 = n_chk;
    got_q.delete();
    send_frame(64'h0102030405060708, 8'h09, 0, 1'b1, 1'b1);
    exp_err = sat_add(exp_err, 1);
    idle(3, 1'b1);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL badchk_no_packet got=%0d want=0", got_q.size()); end
    total++; if (n_chk - c0 != 1) begin bad++; $display("FAIL badchk_pulses got=%0d want=1", n_chk - c0); end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL badchk_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_random;
    int c0 = n_chk, o0 = n_ovr, t0 = n_to;
    int exp_bad = 0;
    logic [63:0] p;
    logic [7:0] chk, j;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom);
        if (j == SOF) j = 8'h5A;
        drive(1'b1, j, 1'b1);
        idle($urandom_range(0, 2), 1'b1);
      end
      p   = {$urandom, $urandom};
      chk = xsum(p);
      if ($urandom_range(0, 3) == 0) chk ^= 8'(1 << $urandom_range(0, 7));
      send_frame(p, chk, 3, 1'b1, 1'b1);
      if (chk == xsum(p)) exp_q.push_back(p);
      else begin
        exp_bad++;
        exp_err = sat_add(exp_err, 1);
      end
    end
    idle(3, 1'b1);
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_packet_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_packet[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (n_chk - c0 != exp_bad) begin bad++; $display("FAIL rand_chk_pulses got=%0d want=%0d", n_chk - c0, exp_bad); end
    total++; if (n_ovr != o0 || n_to != t0) begin
      bad++; $display("FAIL rand_other_errors got=%0d want=0", n_ovr - o0 + n_to - t0);
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL rand_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_overrun;
    int o0 = n_ovr;
    logic [63:0] a = 64'h1111_2222_3333_4444;
    logic [63:0] b = 64'hA5A5_0000_FFFF_0102;
    logic [63:0] d = 64'hDEAD_BEEF_0BAD_F00D;
    logic [63:0] e = 64'h0123_4567_89AB_CDEF;
    got_q.delete();
    send_frame(a, xsum(a), 0, 1'b0, 1'b0);
    send_frame(b, xsum(b), 0, 1'b0, 1'b0);
    exp_err = sat_add(exp_err, 1);
    idle(2, 1'b0);
    total++; if (pkt_valid !== 1'b1 || pkt_data !== a) begin
      bad++; $display("FAIL ovr_held got=%0b/%h want=1/%h", pkt_valid, pkt_data, a);
    end
    total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", n_ovr - o0); end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL ovr_err_count got=%0d want=%0d", err_count, exp_err); end
    idle(1, 1'b1);
    idle(1, 1'b0);
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain pkt_valid got=%0b want=0", pkt_valid); end
    send_frame(d, xsum(d), 0, 1'b0, 1'b0);
    send_frame(e, xsum(e), 0, 1'b0, 1'b1);
    idle(2, 1'b0);
    total++; if (pkt_valid !== 1'b1 || pkt_data !== e) begin
      bad++; $display("FAIL simul_accept_load got=%0b/%h want=1/%h", pkt_valid, pkt_data, e);
    end
    total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL simul_accept_no_ovr got=%0d want=1", n_ovr - o0); end
    idle(1, 1'b1);
    idle(1, 1'b0);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL ovr_accept_count got=%0d want=3", got_q.size()); end
    else begin
      total++; if (got_q[0] !== a || got_q[1] !== d || got_q[2] !== e) begin
        bad++; $display("FAIL ovr_accept_order got=%h,%h,%h want=%h,%h,%h", got_q[0], got_q[1], got_q[2], a, d, e);
      end
    end
  endtask

  task automatic test_timeout;
    int t0 = n_to;
    logic [63:0] p = 64'h0F1E_2D3C_4B5A_6978;
    got_q.delete();
    drive(1'b1, SOF, 1'b1);
    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h22, 1'b1);
    idle(TO - 1, 1'b1);
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b want=0", err_timeout); end
    idle(1, 1'b1);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%0b want=1", err_timeout); end
    exp_err = sat_add(exp_err, 1);
    idle(2, 1'b1);
    total++; if (n_to - t0 != 1) begin bad++; $display("FAIL timeout_count got=%0d want=1", n_to - t0); end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL timeout_err_count got=%0d want=%0d", err_count, exp_err); end
    send_frame(p, xsum(p), 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    total++; if (got_q.size() != 1 || got_q[0] !== p) begin
      bad++; $display("FAIL timeout_recover got=%0d pkts want=1 of %h", got_q.size(), p);
    end
    got_q.delete();
    drive(1'b1, SOF, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) idle(TO - 1, 1'b1);
      drive(1'b1, p[8*i +: 8], 1'b1);
    end
    idle(TO - 1, 1'b1);
    drive(1'b1, xsum(p), 1'b1);
    idle(2, 1'b1);
    total++; if (n_to - t0 != 1) begin bad++; $display("FAIL threshold_no_timeout got=%0d want=1", n_to - t0); end
    total++; if (got_q.size() != 1 || got_q[0] !== p) begin
      bad++; $display("FAIL threshold_packet got=%0d pkts want=1 of %h", got_q.size(), p);
    end
  endtask

  task automatic test_hunt;
    int e0 = n_chk + n_ovr + n_to;
    logic [63:0] p = 64'hA5A5_A5A5_0000_00A5;
    got_q.delete();
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'hFF, 1'b1);
    drive(1'b1, 8'h5A, 1'b1);
    send_frame(p, xsum(p), 1, 1'b1, 1'b1);
    idle(2, 1'b1);
    total++; if (n_chk + n_ovr + n_to != e0) begin bad++; $display("FAIL hunt_no_errors got=%0d want=0", n_chk + n_ovr + n_to - e0); end
    total++; if (got_q.size() != 1 || got_q[0] !== p) begin
      bad++; $display("FAIL hunt_packet got=%0d pkts want=1 of %h", got_q.size(), p);
    end
  endtask

  task automatic test_saturation;
    int c0 = n_chk;
    logic [63:0] p;
    for (int f = 0; f < 300; f++) begin
      p = {$urandom, $urandom};
      send_frame(p, ~xsum(p), 0, 1'b1, 1'b1);
      exp_err = sat_add(exp_err, 1);
    end
    idle(2, 1'b1);
    total++; if (n_chk - c0 != 300) begin bad++; $display("FAIL sat_pulses got=%0d want=300", n_chk - c0); end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL sat_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  task automatic test_async_reset;
    logic [63:0] p = 64'h5566_7788_99AA_BBCC;
    drive(1'b1, SOF, 1'b1);
    drive(1'b1, 8'h10, 1'b1);
    drive(1'b1, 8'h20, 1'b1);
    #2 rst = 1'b1;
    #1;
    exp_err = 0;
    total++; if (pkt_valid !== 1'b0 || pkt_data !== 64'h0 || err_count !== 8'd0) begin
      bad++; $display("FAIL arst_payload got=%0b/%h/%0d want=0/0/0", pkt_valid, pkt_data, err_count);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    send_frame(p, xsum(p), 0, 1'b0, 1'b0);
    idle(1, 1'b0);
    total++; if (pkt_valid !== 1'b1 || pkt_data !== p) begin
      bad++; $display("FAIL arst_reframe got=%0b/%h want=1/%h", pkt_valid, pkt_data, p);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (pkt_valid !== 1'b0 || pkt_data !== 64'h0) begin
      bad++; $display("FAIL arst_buffer got=%0b/%h want=0/0", pkt_valid, pkt_data);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(~p, xsum(~p), 1, 1'b1, 1'b1);
    idle(2, 1'b1);
    total++; if (got_q.size() != 1 || got_q[0] !== ~p) begin
      bad++; $display("FAIL arst_after got=%0d pkts want=1 of %h", got_q.size(), ~p);
    end
    total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL arst_err_count got=%0d want=%0d", err_count, exp_err); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_check();
    test_random();
    test_overrun();
    test_timeout();
    test_hunt();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_packet_framer.md
# usb_packet_framer

Byte-stream-to-packet framer sitting directly upstream of the packet analyzer. It takes the decoded 8-bit byte stream recovered from the USB-C controller's UART/decoder path, hunts for a start-of-frame byte, and collects eight payload bytes and one XOR check byte. It then presents each verified 64-bit packet to the analyzer over a valid/ready handshake with a one-entry output buffer. Malformed, stalled or overrun frames are dropped, flagged and counted.

## Interface
- SOF, 8'hA5: start-of-frame marker byte.
- TIMEOUT_CYCLES, 1024: maximum idle clocks between bytes inside a frame, ≥2.
- ERR_CNT_W, 8: error counter width.

- clk  input  1  sole clock; one clock; reset is asynchronous and active-high.
- rst  input  1  asynchronous, active-high reset.
- in_byte  input  8  decoded byte from the decoder stage.
- in_valid  input  1  single-cycle strobe, in_byte valid; no backpressure, never stalled.
- pkt_data  output  64  assembled payload; first payload byte in [63:56].
- pkt_valid  output  1  pkt_data holds an unconsumed packet.
- pkt_ready  input  1  analyzer accepts pkt_data when high with pkt_valid.
- err_chk  output  1  one-cycle pulse, check byte mismatch.
- err_overrun  output  1  one-cycle pulse, good frame dropped because the buffer was full.
- err_timeout  output  1  one-cycle pulse, frame aborted by inter-byte timeout.
- err_count  output  ERR_CNT_W  saturating count of all error pulses.

## Operation
- States: IDLE, PAYLOAD, CHECK.
- IDLE:
  - An in_valid byte equal to SOF moves to PAYLOAD, clears the byte index (0..7) and clears the running XOR.
  - Any other byte is discarded silently, with no error.
- PAYLOAD:
  - Each in_valid byte shifts into the assembly register at the index position (byte 0 → bits [63:56]) and XORs into the running checksum. The index increments.
  - After byte 7 the state moves to CHECK.
  - SOF-valued bytes are treated as data. No resync happens mid-frame.
- CHECK, on the in_valid byte, always returning to IDLE:
  - If the byte equals the running XOR and the buffer is free, the packet is loaded into pkt_data and pkt_valid is set.
  - The buffer counts as free when pkt_valid=0, or when pkt_valid=1 and pkt_ready=1 in the same cycle.
  - If the byte equals the running XOR and the buffer is not free, the frame is dropped, err_overrun pulses, and pkt_data/pkt_valid are unchanged.
  - If the byte does not match, the frame is dropped and err_chk pulses.
- Timeout:
  - An idle counter runs only in PAYLOAD/CHECK. It clears on every in_valid and on entry to PAYLOAD.
  - When it reaches TIMEOUT_CYCLES-1 with in_valid=0, the state returns to IDLE and err_timeout pulses.
  - If in_valid arrives on the threshold cycle, the byte wins and no timeout occurs.
- Handshake:
  - pkt_valid clears on a cycle with pkt_valid & pkt_ready, unless a new packet loads that same cycle, in which case it stays high with the new data.
  - pkt_data is stable while pkt_valid=1 and not accepted.
- err_count increments by one for each error pulse and saturates at all-ones. At most one error pulse occurs per cycle by construction.

## Timing
- Reset values:
  - State IDLE.
  - pkt_data=0, pkt_valid=0.
  - All err pulses 0, err_count=0.
  - Index, XOR and idle counter all 0.
- Reset mid-frame discards the partial frame. Reset with pkt_valid=1 discards the buffered packet.
- All outputs are registered.
- pkt_valid rises the clock after the check byte's in_valid cycle, giving 1-cycle latency from the check byte.
- Error pulses assert the clock after the causing event and last exactly one cycle.
- Back-to-back frames with no gap (SOF directly after the check byte) are accepted.
- Minimum frame length is 10 in_valid cycles.

## Test plan
- Good frame:
  - Stimulus: A5,01,02,03,04,05,06,07,08, check 08, pkt_ready=1.
  - Response: pkt_valid high for one cycle with pkt_data=64'h0102030405060708; no errors; err_count=0.
- Bad check:
  - Stimulus: same frame, check byte 09.
  - Response: no pkt_valid; err_chk pulses once; err_count=1.
- Overrun and simultaneous accept:
  - Stimulus: hold pkt_ready=0 and send two good frames.
  - Response: the first frame is held; the second gives err_overrun.
  - Stimulus: repeat with pkt_ready raised exactly on the second check byte's cycle.
  - Response: the second packet loads; pkt_valid stays high; no overrun.
- Timeout:
  - Stimulus: A5,11,22, then silence for TIMEOUT_CYCLES cycles.
  - Response: err_timeout pulses once.
  - Stimulus: a following good frame.
  - Response: the frame is framed correctly.
  - Stimulus: a byte arriving exactly on the threshold cycle.
  - Response: no timeout.
- Hunt and saturation:
  - Stimulus: junk bytes 00,FF,5A before SOF.
  - Response: ignored, no errors.
  - Stimulus: 300 bad-check frames with ERR_CNT_W=8.
  - Response: err_count saturates at 255.
- Async reset:
  - Stimulus: assert rst between clock edges mid-PAYLOAD and with pkt_valid=1.
  - Response: all outputs go to reset values immediately; the next frame after release is assembled correctly.
